// File: rtl/parking_meter_gen_pkg.sv
// Shared parking-meter definitions: mode encoding, 7-segment decode, default coin table.
package parking_meter_gen_pkg;

  typedef enum logic [1:0] {
    PM_NORMAL  = 2'b00,
    PM_LOW     = 2'b01,
    PM_EXPIRED = 2'b10
  } pm_mode_e;

  localparam int COIN_W = 14;

  // Slice i is the value of add[i]: add[0]=60, add[1]=180, add[2]=120, add[3]=300.
  localparam logic [4*COIN_W-1:0] COINVAL_DEFAULT = {14'd300, 14'd120, 14'd180, 14'd60};

  // Segments {g..a}, active-low; non-decimal codes are blank.
  function automatic logic [6:0] seg7_bcd(input logic [3:0] d);
    logic [6:0] seg_on;
    case (d)
      4'd0:    seg_on = 7'h3F;
      4'd1:    seg_on = 7'h06;
      4'd2:    seg_on = 7'h5B;
      4'd3:    seg_on = 7'h4F;
      4'd4:    seg_on = 7'h66;
      4'd5:    seg_on = 7'h6D;
      4'd6:    seg_on = 7'h7D;
      4'd7:    seg_on = 7'h07;
      4'd8:    seg_on = 7'h7F;
      4'd9:    seg_on = 7'h6F;
      default: seg_on = 7'h00;
    endcase
    return ~seg_on;
  endfunction

  function automatic pm_mode_e mode_of(input int cnt, input int low_thresh);
    if (cnt == 0) return PM_EXPIRED;
    if (cnt < low_thresh) return PM_LOW;
    return PM_NORMAL;
  endfunction

endpackage

// File: rtl/parking_meter_gen_bin2bcd.sv
// Combinational double-dabble binary to NDIG-digit BCD; inputs are never above 10**NDIG-1.
module parking_meter_gen_bin2bcd #(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic [BW-1:0]     bin,
  output logic [4*NDIG-1:0] bcd
);

  logic [4*NDIG-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      for (int d = 0; d < NDIG; d++) begin
        if (acc[4*d +: 4] >= 4'd5) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*NDIG-2:0], bin[i]};
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/parking_meter_gen.sv
// Parking-meter core: coin/preset-loaded seconds countdown, blink modes, multiplexed 7-seg drive.
// Define PM_EDGE_DETECT_EN to rising-edge detect add/rst1/rst2 (one extra cycle of input latency).
module parking_meter_gen
  import parking_meter_gen_pkg::*;
#(
  parameter int                       NDIG       = 4,
  parameter int                       NCOIN      = 4,
  parameter logic [NCOIN*COIN_W-1:0]  COINVAL    = COINVAL_DEFAULT,
  parameter int                       PRESET1    = 15,
  parameter int                       PRESET2    = 150,
  parameter int                       LOW_THRESH = 180,
  parameter int                       TICK_DIV   = 100,
  parameter int                       SCAN_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCOIN-1:0]  add,
  input  logic              rst1,
  input  logic              rst2,
  output logic [6:0]        led_seg,
  output logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] val,
  output logic [1:0]        mode
);

  localparam int MAXCNT = 10**NDIG - 1;
  localparam int CW     = $clog2(MAXCNT + 1);
  localparam int PW     = $clog2(TICK_DIV + 1);
  localparam int SW     = $clog2(SCAN_DIV + 1);
  localparam int IW     = $clog2(NDIG);

  logic [NCOIN-1:0] coin_s;
  logic             p1_s;
  logic             p2_s;

`ifdef PM_EDGE_DETECT_EN
  logic [NCOIN+1:0] in_prev_q, in_prev_d;
  logic [NCOIN+1:0] in_edge_q, in_edge_d;

  always_comb begin
    in_prev_d = {rst2, rst1, add};
    in_edge_d = in_prev_d & ~in_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_prev_q <= '0;
      in_edge_q <= '0;
    end else begin
      in_prev_q <= in_prev_d;
      in_edge_q <= in_edge_d;
    end
  end

  assign coin_s = in_edge_q[NCOIN-1:0];
  assign p1_s   = in_edge_q[NCOIN];
  assign p2_s   = in_edge_q[NCOIN+1];
`else
  assign coin_s = add;
  assign p1_s   = rst1;
  assign p2_s   = rst2;
`endif

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              hp_q, hp_d;
  logic              sec_q, sec_d;
  logic [SW-1:0]     sd_q, sd_d;
  logic [IW-1:0]     idx_q, idx_d;
  pm_mode_e          mode_q, mode_d;
  logic [4*NDIG-1:0] val_q, val_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [31:0]       coin_sum;
  logic [31:0]       total;
  logic              tick;
  logic              half;
  logic              preset;
  logic              lit;
  logic [4*NDIG-1:0] bcd;

  // Count datapath and second/half-second phase.
  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < NCOIN; i++) begin
      if (coin_s[i]) coin_sum = coin_sum + 32'(COINVAL[i*COIN_W +: COIN_W]);
    end
    tick   = (presc_q == PW'(TICK_DIV - 1));
    half   = (presc_q == PW'(TICK_DIV / 2));
    preset = p1_s | p2_s;
    // A zero count is never decremented, so the subtraction cannot underflow.
    total  = 32'(count_q) + coin_sum - 32'(tick && (count_q != '0));

    if (p2_s)                      count_d = CW'(PRESET2);
    else if (p1_s)                 count_d = CW'(PRESET1);
    else if (total > 32'(MAXCNT))  count_d = CW'(MAXCNT);
    else                           count_d = total[CW-1:0];

    presc_d = (preset || tick) ? '0 : presc_q + 1'b1;
    hp_d    = preset ? 1'b0 : (hp_q ^ (tick | half));
    sec_d   = preset ? 1'b0 : (sec_q ^ tick);
  end

  parking_meter_gen_bin2bcd #(
    .NDIG (NDIG),
    .BW   (CW)
  ) u_bin2bcd (
    .bin (count_d),
    .bcd (bcd)
  );

  // Mode and BCD track the next count so they land in the same cycle as the count.
  always_comb begin
    mode_d = mode_of(32'(count_d), LOW_THRESH);
    val_d  = bcd;
  end

  always_comb begin
    sd_d  = sd_q + 1'b1;
    idx_d = idx_q;
    if (sd_q == SW'(SCAN_DIV - 1)) begin
      sd_d  = '0;
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end

    case (mode_q)
      PM_NORMAL: lit = 1'b1;
      PM_LOW:    lit = ~sec_q;
      default:   lit = ~hp_q;
    endcase

    an_d  = '1;
    seg_d = 7'h7F;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg7_bcd(val_q[4*idx_q +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      presc_q <= '0;
      hp_q    <= 1'b0;
      sec_q   <= 1'b0;
      sd_q    <= '0;
      idx_q   <= '0;
      mode_q  <= PM_EXPIRED;
      val_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      hp_q    <= hp_d;
      sec_q   <= sec_d;
      sd_q    <= sd_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign led_seg = seg_q;
  assign an      = an_q;
  assign val     = val_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_parking_meter_gen.sv
// Bench for parking_meter_gen at default parameters; follows PM_EDGE_DETECT_EN when it is defined.
`timescale 1ns/1ps
module tb_parking_meter_gen;

  localparam int NDIG = 4;
  localparam int TD   = 100;
  localparam int SD   = 4;
  localparam int LOWT = 180;
  localparam int P1   = 15;
  localparam int P2   = 150;
  localparam int MAXC = 9999;
`ifdef PM_EDGE_DETECT_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 1;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        rst1 = 1'b0;
  logic        rst2 = 1'b0;
  logic [3:0]  add  = 4'h0;
  logic [6:0]  led_seg;
  logic [3:0]  an;
  logic [15:0] val;
  logic [1:0]  mode;

  int n_chk  = 0;
  int n_pass = 0;

  int         coin_val [4] = '{60, 180, 120, 300};
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  parking_meter_gen dut (
    .clk     (clk),
    .rst     (rst),
    .add     (add),
    .rst1    (rst1),
    .rst2    (rst2),
    .led_seg (led_seg),
    .an      (an),
    .val     (val),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_bcd(int c);
    return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  function automatic logic [1:0] exp_mode(int c);
    if (c == 0) return 2'b10;
    if (c < LOWT) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: m_ph = cycles since the last phase restart, m_cyc = cycles since reset.
  int         m_cnt = 0;
  int         m_ph  = 0;
  int         m_cyc = 0;
  logic [3:0] m_an  = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic [5:0] m_prev = '0;
  logic [5:0] m_edge = '0;

  always @(posedge clk) begin
    logic [5:0] raw;
    logic [5:0] eff;
    int         sum;
    int         idx;
    int         dig;
    bit         lit;
    bit         tick;
    raw = {rst2, rst1, add};
    if (rst) begin
      m_cnt = 0; m_ph = 0; m_cyc = 0;
      m_an = 4'hF; m_seg = 7'h7F;
      m_prev = '0; m_edge = '0;
    end else begin
`ifdef PM_EDGE_DETECT_EN
      eff    = m_edge;
      m_edge = raw & ~m_prev;
      m_prev = raw;
`else
      eff = raw;
`endif
      idx = (m_cyc / SD) % NDIG;
      dig = m_cnt;
      for (int k = 0; k < idx; k++) dig = dig / 10;
      dig = dig % 10;
      case (exp_mode(m_cnt))
        2'b00:   lit = 1'b1;
        2'b01:   lit = ((m_ph / TD) % 2) == 0;
        default: lit = (m_ph % TD) <= TD / 2;
      endcase
      m_an  = lit ? ~(4'b0001 << idx) : 4'hF;
      m_seg = lit ? seg_tbl[dig] : 7'h7F;

      tick = (m_ph % TD) == TD - 1;
      sum  = 0;
      for (int i = 0; i < 4; i++) if (eff[i]) sum += coin_val[i];
      if (eff[5]) begin
        m_cnt = P2; m_ph = 0;
      end else if (eff[4]) begin
        m_cnt = P1; m_ph = 0;
      end else begin
        m_cnt = m_cnt + sum - ((tick && m_cnt > 0) ? 1 : 0);
        if (m_cnt > MAXC) m_cnt = MAXC;
        m_ph++;
      end
      m_cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] a, input logic p1, input logic p2);
    add = a; rst1 = p1; rst2 = p2;
    step(1);
    add = 4'h0; rst1 = 1'b0; rst2 = 1'b0;
    step(LAT - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n_chk++; if (val !== 16'h0000) $display("FAIL reset_val got %h want 0000", val); else n_pass++;
    n_chk++; if (mode !== 2'b10) $display("FAIL reset_mode got %b want 10", mode); else n_pass++;
    n_chk++; if (an !== 4'hF) $display("FAIL reset_an got %h want f", an); else n_pass++;
    n_chk++; if (led_seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", led_seg); else n_pass++;
    for (int c = 0; c < 150; c++) begin
      step(1);
      n_chk++; if (val !== 16'h0000 || mode !== 2'b10)
        $display("FAIL reset_hold c=%0d got %h/%b want 0000/10", c, val, mode); else n_pass++;
      n_chk++; if (an !== m_an) $display("FAIL reset_an c=%0d got %h want %h", c, an, m_an); else n_pass++;
      n_chk++; if (led_seg !== m_seg) $display("FAIL reset_seg c=%0d got %h want %h", c, led_seg, m_seg); else n_pass++;
    end
  endtask

  task automatic test_coin_low();
    do_reset();
    step(10);
    pulse(4'b0100, 1'b0, 1'b0);
    n_chk++; if (val !== 16'h0120) $display("FAIL coin2_val got %h want 0120", val); else n_pass++;
    n_chk++; if (mode !== 2'b01) $display("FAIL coin2_mode got %b want 01", mode); else n_pass++;
    step(100);
    n_chk++; if (val !== 16'h0119) $display("FAIL coin2_tick got %h want 0119", val); else n_pass++;
    for (int c = 0; c < 300; c++) begin
      step(1);
      n_chk++; if (val !== exp_bcd(m_cnt)) $display("FAIL low_val c=%0d got %h want %h", c, val, exp_bcd(m_cnt)); else n_pass++;
      n_chk++; if (an !== m_an) $display("FAIL low_blink c=%0d got %h want %h", c, an, m_an); else n_pass++;
      n_chk++; if (led_seg !== m_seg) $display("FAIL low_seg c=%0d got %h want %h", c, led_seg, m_seg); else n_pass++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(3);
    repeat (35) pulse(4'b1000, 1'b0, 1'b0);
    n_chk++; if (val !== 16'h9999) $display("FAIL sat_val got %h want 9999", val); else n_pass++;
    n_chk++; if (mode !== 2'b00) $display("FAIL sat_mode got %b want 00", mode); else n_pass++;
    pulse(4'b0001, 1'b0, 1'b0);
    n_chk++; if (val !== 16'h9999) $display("FAIL sat_hold got %h want 9999", val); else n_pass++;
    do_reset();
    step(3);
    pulse(4'b1111, 1'b0, 1'b0);
    n_chk++; if (val !== 16'h0660) $display("FAIL all_coins got %h want 0660", val); else n_pass++;
    n_chk++; if (mode !== 2'b00) $display("FAIL all_mode got %b want 00", mode); else n_pass++;
  endtask

  task automatic test_preset();
    do_reset();
    step(37);
    pulse(4'b0000, 1'b1, 1'b0);
    n_chk++; if (val !== 16'h0015) $display("FAIL p1_val got %h want 0015", val); else n_pass++;
    n_chk++; if (mode !== 2'b01) $display("FAIL p1_mode got %b want 01", mode); else n_pass++;
    step(99);
    n_chk++; if (val !== 16'h0015) $display("FAIL p1_pretick got %h want 0015", val); else n_pass++;
    step(1);
    n_chk++; if (val !== 16'h0014) $display("FAIL p1_tick got %h want 0014", val); else n_pass++;
    pulse(4'b0000, 1'b1, 1'b1);
    n_chk++; if (val !== 16'h0150) $display("FAIL p12_val got %h want 0150", val); else n_pass++;
    pulse(4'b1000, 1'b1, 1'b0);
    n_chk++; if (val !== 16'h0015) $display("FAIL p1_coin got %h want 0015", val); else n_pass++;
  endtask

  task automatic test_tick_coin();
    pulse(4'b0000, 1'b1, 1'b0);
    step(1400);
    n_chk++; if (val !== 16'h0001) $display("FAIL one_val got %h want 0001", val); else n_pass++;
    step(100 - LAT);
    pulse(4'b0001, 1'b0, 1'b0);
    n_chk++; if (val !== 16'h0060) $display("FAIL tick_coin got %h want 0060", val); else n_pass++;
    pulse(4'b0000, 1'b1, 1'b0);
    step(1400);
    n_chk++; if (val !== 16'h0001) $display("FAIL one_val2 got %h want 0001", val); else n_pass++;
    step(100);
    n_chk++; if (val !== 16'h0000) $display("FAIL zero_val got %h want 0000", val); else n_pass++;
    n_chk++; if (mode !== 2'b10) $display("FAIL zero_mode got %b want 10", mode); else n_pass++;
    step(250);
    n_chk++; if (val !== 16'h0000) $display("FAIL zero_hold got %h want 0000", val); else n_pass++;
  endtask

  task automatic test_hold();
    logic [15:0] exp1;
    logic [15:0] exp2;
`ifdef PM_EDGE_DETECT_EN
    exp1 = 16'h0210;
    exp2 = 16'h0509;
`else
    exp1 = 16'h3150;
    exp2 = 16'h9999;
`endif
    pulse(4'b0000, 1'b0, 1'b1);
    add = 4'b0001;
    step(50);
    add = 4'b0000;
    step(2);
    n_chk++; if (val !== exp1) $display("FAIL hold_add0 got %h want %h", val, exp1); else n_pass++;
    add = 4'b1000;
    step(50);
    add = 4'b0000;
    step(2);
    n_chk++; if (val !== exp2) $display("FAIL hold_add3 got %h want %h", val, exp2); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) add[i] = ($urandom_range(149) == 0);
      rst1 = ($urandom_range(199) == 0);
      rst2 = ($urandom_range(299) == 0);
      rst  = ($urandom_range(999) == 0);
      step(1);
      n_chk++; if (val !== exp_bcd(m_cnt)) $display("FAIL rnd_val c=%0d got %h want %h", c, val, exp_bcd(m_cnt)); else n_pass++;
      n_chk++; if (mode !== exp_mode(m_cnt)) $display("FAIL rnd_mode c=%0d got %b want %b", c, mode, exp_mode(m_cnt)); else n_pass++;
      n_chk++; if (an !== m_an) $display("FAIL rnd_an c=%0d got %h want %h", c, an, m_an); else n_pass++;
      n_chk++; if (led_seg !== m_seg) $display("FAIL rnd_seg c=%0d got %h want %h", c, led_seg, m_seg); else n_pass++;
    end
    add = 4'h0; rst1 = 1'b0; rst2 = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_coin_low();
    test_saturate();
    test_preset();
    test_tick_coin();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
